// File: rtl/systolic_pe_sequencer_pkg.sv
// Shared types and constants for the systolic PE sequencer: FSM state
// encoding, datapath widths and default timing/buffer parameters.
package systolic_pe_sequencer_pkg;

  localparam int unsigned SAMPLE_W         = 16;
  localparam int unsigned RESULT_W         = 32;
  localparam int unsigned FRAME_CNT_W      = 16;
  localparam int unsigned FRAME_CYCLES_DEF = 30;
  localparam int unsigned FIFO_DEPTH_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    HOLD,
    FLUSH
  } state_t;

  function automatic logic [RESULT_W-1:0] sign_extend(input logic [SAMPLE_W-1:0] s);
    return {{(RESULT_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/systolic_pe_sequencer_if.sv
// Sample-in, result-out and PE-side signals of the sequencer.
// slave: the sequencer's view; master: the surrounding upstream/downstream/PE.
interface systolic_pe_sequencer_if;
  import systolic_pe_sequencer_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_data;
  logic                m_valid;
  logic                m_ready;
  logic [RESULT_W-1:0] m_data;
  logic [SAMPLE_W-1:0] pe_xin;
  logic                pe_rst;
  logic [SAMPLE_W-1:0] pe_yout;

  modport slave (
    input  s_valid, s_data, m_ready, pe_yout,
    output s_ready, m_valid, m_data, pe_xin, pe_rst
  );

  modport master (
    output s_valid, s_data, m_ready, pe_yout,
    input  s_ready, m_valid, m_data, pe_xin, pe_rst
  );

endinterface

// File: rtl/systolic_pe_sequencer_fifo.sv
// Input sample buffer: power-of-two depth FIFO with full/empty flags.
// Pointers carry one extra wrap bit to tell full from empty.
module sample_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/systolic_pe_sequencer.sv
// Feeds buffered samples to a systolic PE, holding each for FRAME_CYCLES
// clocks, and captures the sign-extended PE output once per frame.
module systolic_pe_sequencer
  import systolic_pe_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                   clk30x,
  input  logic                   rst,
  systolic_pe_sequencer_if.slave bus,
  input  logic                   flush,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned CNT_W = (FRAME_CYCLES > 3) ? $clog2(FRAME_CYCLES) : 2;

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cyc_cnt;
  logic                flush_pend;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic [SAMPLE_W-1:0] xin_q;
  logic [RESULT_W-1:0] mdata_q;
  logic                mvalid_q;
  logic                pe_rst_q;
  logic                load_en;
  logic                capture_en;
  logic                flush_enter;
  logic                flush_exit;

  // Pushes are refused while a flush waits so the buffer can drain.
  assign push        = bus.s_valid && bus.s_ready;
  assign bus.s_ready = !fifo_full && !flush_pend;
  assign bus.pe_xin  = xin_q;
  assign bus.pe_rst  = pe_rst_q;
  assign bus.m_data  = mdata_q;
  assign bus.m_valid = mvalid_q;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk   (clk30x),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk30x or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!fifo_empty)                  state_nx = LOAD;
        else if (flush_pend && !mvalid_q) state_nx = FLUSH;
      end
      LOAD:    state_nx = (FRAME_CYCLES > 2) ? RUN : CAPTURE;
      RUN: begin
        if (cyc_cnt >= CNT_W'(FRAME_CYCLES - 2)) state_nx = CAPTURE;
      end
      // An unconsumed result parks the new one in HOLD instead of overwriting.
      CAPTURE: begin
        if (mvalid_q && !bus.m_ready) state_nx = HOLD;
        else if (!fifo_empty)         state_nx = LOAD;
        else                          state_nx = IDLE;
      end
      HOLD: begin
        if (bus.m_ready) state_nx = fifo_empty ? IDLE : LOAD;
      end
      FLUSH: begin
        if (cyc_cnt == CNT_W'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_en     = (state == LOAD);
    pop         = load_en;
    capture_en  = ((state == CAPTURE) && !(mvalid_q && !bus.m_ready)) ||
                  ((state == HOLD) && bus.m_ready);
    flush_enter = (state == IDLE) && (state_nx == FLUSH);
    flush_exit  = (state == FLUSH) && (state_nx == IDLE);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk30x or posedge rst) begin
    if (rst) begin
      cyc_cnt    <= '0;
      xin_q      <= '0;
      pe_rst_q   <= 1'b1;
      mdata_q    <= '0;
      mvalid_q   <= 1'b0;
      frame_cnt  <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (load_en)                             cyc_cnt <= CNT_W'(1);
      else if (state == RUN || state == FLUSH) cyc_cnt <= cyc_cnt + CNT_W'(1);
      else if (flush_enter)                    cyc_cnt <= '0;

      if (load_en)          xin_q <= fifo_dout;
      else if (flush_enter) xin_q <= '0;

      if (load_en || flush_exit) pe_rst_q <= 1'b0;
      else if (flush_enter)      pe_rst_q <= 1'b1;

      if (capture_en) mdata_q <= sign_extend(bus.pe_yout);

      if (capture_en)                   mvalid_q <= 1'b1;
      else if (mvalid_q && bus.m_ready) mvalid_q <= 1'b0;

      if (flush_enter)     frame_cnt <= '0;
      else if (capture_en) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);

      if (flush_enter) flush_pend <= 1'b0;
      else if (flush)  flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_pe_sequencer.sv
// Directed bench for systolic_pe_sequencer with an echo PE (yout = xin).
module tb_systolic_pe_sequencer;

  logic        clk30x = 1'b0;
  logic        rst    = 1'b1;
  logic        flush  = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;
  int          total  = 0;
  int          bad    = 0;
  int          cyc    = 0;

  systolic_pe_sequencer_if bus ();

  systolic_pe_sequencer #(
    .FRAME_CYCLES (30),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk30x    (clk30x),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk30x = ~clk30x;
  always @(posedge clk30x) cyc <= cyc + 1;
  assign bus.pe_yout = bus.pe_xin;

  typedef struct {
    logic [15:0] sample;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [31:0] sext(input logic [15:0] d);
    return {{16{d[15]}}, d};
  endfunction

  task automatic tick();
    @(posedge clk30x);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] d, output int pc);
    int n;
    n = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (bus.s_ready !== 1'b1) check("push_ready_timeout", {31'b0, bus.s_ready}, 32'd1);
    tick();
    pc = cyc;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int vc);
    int n;
    n = 0;
    while (bus.m_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (bus.m_valid !== 1'b1) check("m_valid_timeout", {31'b0, bus.m_valid}, 32'd1);
    vc = cyc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pe_rst"},    {31'b0, bus.pe_rst},  32'd1);
    check({tag, "_pe_xin"},    {16'b0, bus.pe_xin},  32'd0);
    check({tag, "_m_data"},    bus.m_data,           32'd0);
    check({tag, "_frame_cnt"}, {16'b0, frame_cnt},   32'd0);
    check({tag, "_m_valid"},   {31'b0, bus.m_valid}, 32'd0);
    check({tag, "_busy"},      {31'b0, busy},        32'd0);
    check({tag, "_s_ready"},   {31'b0, bus.s_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, vc, prev, h, n;
    int pcs [9];
    logic [15:0] bb [9];
    logic stable, frozen, quiet;
    logic [15:0] xin_seen;

    vecs[0] = '{16'h0100, 32'h0000_0100, 16'd1};
    vecs[1] = '{16'h8001, 32'hFFFF_8001, 16'd2};
    vecs[2] = '{16'h7FFF, 32'h0000_7FFF, 16'd3};
    vecs[3] = '{16'hFFFF, 32'hFFFF_FFFF, 16'd4};
    vecs[4] = '{16'h0000, 32'h0000_0000, 16'd5};
    bb = '{16'h0011, 16'h8000, 16'h7FFF, 16'h1234, 16'hFEDC,
           16'h0001, 16'hC000, 16'h4321, 16'hFFFE};

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;

    repeat (2) @(posedge clk30x);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;
    tick();
    check("s_ready_after_release", {31'b0, bus.s_ready}, 32'd1);
    check("pe_rst_before_load",    {31'b0, bus.pe_rst},  32'd1);

    // Single-sample frames: latency, sign extension, frame counting.
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].sample, pc);
      tick();
      check($sformatf("v%0d_busy_load", i), {31'b0, busy}, 32'd1);
      tick();
      check($sformatf("v%0d_pe_xin", i), {16'b0, bus.pe_xin}, {16'b0, vecs[i].sample});
      check($sformatf("v%0d_pe_rst", i), {31'b0, bus.pe_rst}, 32'd0);
      wait_valid(60, vc);
      check($sformatf("v%0d_latency", i), 32'(vc - pc), 32'd31);
      check($sformatf("v%0d_m_data", i), bus.m_data, vecs[i].exp_data);
      check($sformatf("v%0d_frame_cnt", i), {16'b0, frame_cnt}, {16'b0, vecs[i].exp_cnt});
      tick();
      check($sformatf("v%0d_m_valid_clear", i), {31'b0, bus.m_valid}, 32'd0);
      check($sformatf("v%0d_idle", i), {31'b0, busy}, 32'd0);
    end

    // Nine back-to-back samples: fill to full, ordered results 30 apart.
    do_reset();
    for (int i = 0; i < 9; i++) push(bb[i], pcs[i]);
    check("b2b_push_spacing", 32'(pcs[8] - pcs[0]), 32'd8);
    check("b2b_full", {31'b0, bus.s_ready}, 32'd0);
    prev = 0;
    for (int i = 0; i < 9; i++) begin
      wait_valid(80, vc);
      if (i == 0) check("b2b_first_latency", 32'(vc - pcs[0]), 32'd31);
      else        check($sformatf("b2b_spacing_%0d", i), 32'(vc - prev), 32'd30);
      check($sformatf("b2b_data_%0d", i), bus.m_data, sext(bb[i]));
      prev = vc;
      tick();
    end
    check("b2b_frame_cnt", {16'b0, frame_cnt}, 32'd9);

    // Downstream stall: second result parks in HOLD, outputs frozen.
    do_reset();
    bus.m_ready = 1'b0;
    push(16'h1234, pc);
    push(16'hABCD, n);
    push(16'h0F0F, n);
    wait_valid(60, vc);
    check("hold_first_latency", 32'(vc - pc), 32'd31);
    stable = 1'b1;
    frozen = 1'b1;
    xin_seen = '0;
    for (int i = 0; i < 100; i++) begin
      if (bus.m_valid !== 1'b1 || bus.m_data !== 32'h0000_1234) stable = 1'b0;
      if (i == 2) xin_seen = bus.pe_xin;
      if (i > 2 && bus.pe_xin !== xin_seen) frozen = 1'b0;
      tick();
    end
    check("hold_m_data_stable", {31'b0, stable}, 32'd1);
    check("hold_xin_frozen",    {31'b0, frozen}, 32'd1);
    check("hold_pe_xin",        {16'b0, bus.pe_xin}, 32'h0000_ABCD);
    check("hold_frame_cnt",     {16'b0, frame_cnt}, 32'd1);
    check("hold_busy",          {31'b0, busy}, 32'd1);
    bus.m_ready = 1'b1;
    tick();
    h = cyc;
    check("hold_release_valid", {31'b0, bus.m_valid}, 32'd1);
    check("hold_release_data",  bus.m_data, 32'hFFFF_ABCD);
    check("hold_release_cnt",   {16'b0, frame_cnt}, 32'd2);
    tick();
    check("hold_second_taken",  {31'b0, bus.m_valid}, 32'd0);
    wait_valid(60, vc);
    check("hold_third_latency", 32'(vc - h), 32'd30);
    check("hold_third_data",    bus.m_data, 32'h0000_0F0F);
    check("hold_third_cnt",     {16'b0, frame_cnt}, 32'd3);
    tick();

    // Flush during RUN: frame completes, then a 2-cycle PE reset.
    push(16'h5A5A, pc);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_blocks_push", {31'b0, bus.s_ready}, 32'd0);
    check("flush_run_busy",    {31'b0, busy}, 32'd1);
    wait_valid(60, vc);
    check("flush_frame_latency", 32'(vc - pc), 32'd31);
    check("flush_frame_data",    bus.m_data, 32'h0000_5A5A);
    check("flush_frame_cnt",     {16'b0, frame_cnt}, 32'd4);
    n = 0;
    while (bus.pe_rst !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("flush_pe_rst_rise", 32'(cyc - vc), 32'd2);
    check("flush_pe_xin",      {16'b0, bus.pe_xin}, 32'd0);
    check("flush_frame_cnt0",  {16'b0, frame_cnt}, 32'd0);
    n = 0;
    while (bus.pe_rst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("flush_pe_rst_len", 32'(n), 32'd2);
    check("flush_s_ready",    {31'b0, bus.s_ready}, 32'd1);
    check("flush_idle",       {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-frame with samples queued.
    for (int i = 0; i < 4; i++) push(16'h0100 + 16'(i), pcs[i]);
    while (cyc < pcs[0] + 16) tick();
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    #3;
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (bus.m_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("midrst_no_output", {31'b0, quiet}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
